// File: rtl/seg_scroll_if.sv
// Host-side bus of the scrolling 7-segment sequencer: message buffer writes,
// start/stop control, and the registered display/status outputs.
interface seg_scroll_if #(
  parameter int NUM_DIGITS = 3,
  parameter int MSG_DEPTH  = 16
);
  localparam int AW = $clog2(MSG_DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            wr_data;
  logic [AW:0]           msg_len;
  logic                  loop;
  logic                  start;
  logic                  stop;
  logic                  busy;
  logic                  done;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            data;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, loop, start, stop,
    input  busy, done, sel, data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, loop, start, stop,
    output busy, done, sel, data
  );
endinterface

// File: rtl/seg_scroll_ctrl.sv
// Multiplexed 7-segment scroller: refreshes one digit per tick and slides a
// NUM_DIGITS-wide window across a host-written message, once or looping.
//
// state  | meaning
// S_IDLE | display blank, waiting for a valid start
// S_RUN  | refreshing digits and scrolling the window
module seg_scroll_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int SCROLL_TICKS = 300,
  parameter int NUM_DIGITS   = 3,
  parameter int MSG_DEPTH    = 16
) (
  input logic         clk,
  input logic         rst_n,
  seg_scroll_if.slave bus
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int GW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DW-1:0]         DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0]         SCR_LAST = SW'(SCROLL_TICKS - 1);
  localparam logic [GW-1:0]         DIG_LAST = GW'(NUM_DIGITS - 1);
  localparam logic [LW-1:0]         LEN_MAX  = LW'(MSG_DEPTH);
  localparam logic [NUM_DIGITS-1:0] SEL0     = NUM_DIGITS'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [7:0]            mem [MSG_DEPTH];
  logic [0:0]            state;
  logic [LW-1:0]         len;
  logic                  loop_r;
  logic [DW-1:0]         div_cnt, div_n;
  logic [SW-1:0]         scroll_cnt, scroll_n;
  logic [AW-1:0]         offset, offset_n;
  logic [GW-1:0]         dig, dig_n;
  logic                  tick, step, wrap;
  logic [LW-1:0]         sum;
  logic [AW-1:0]         rd_idx;
  logic                  busy_q, done_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [7:0]            data_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sel  = sel_q;
  assign bus.data = data_q;

  // Message buffer: host writes in any state, no reset on contents.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Next refresh/scroll position; digit advance and scroll step combine
  // so the output register always sees the new offset and digit together.
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    div_n    = tick ? '0 : div_cnt + 1'b1;
    dig_n    = dig;
    scroll_n = scroll_cnt;
    step     = 1'b0;
    if (tick) begin
      dig_n = (dig == DIG_LAST) ? '0 : dig + 1'b1;
      if (scroll_cnt == SCR_LAST) begin
        scroll_n = '0;
        step     = 1'b1;
      end else begin
        scroll_n = scroll_cnt + 1'b1;
      end
    end
    wrap     = step && (LW'(offset) == len - 1'b1);
    offset_n = offset;
    if (step) offset_n = wrap ? '0 : offset + 1'b1;
  end

  // Window index (offset + digit) mod len; repeated conditional subtracts
  // cover short messages where the window wraps more than once.
  always_comb begin
    sum = LW'(offset_n) + LW'(dig_n);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sum >= len) sum = sum - len;
    end
    rd_idx = sum[AW-1:0];
  end

  // Control FSM with registered display and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      loop_r     <= 1'b0;
      div_cnt    <= '0;
      scroll_cnt <= '0;
      offset     <= '0;
      dig        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.stop && (bus.msg_len != '0) && (bus.msg_len <= LEN_MAX)) begin
            state      <= S_RUN;
            len        <= bus.msg_len;
            loop_r     <= bus.loop;
            div_cnt    <= '0;
            scroll_cnt <= '0;
            offset     <= '0;
            dig        <= '0;
            busy_q     <= 1'b1;
            sel_q      <= SEL0;
            data_q     <= mem[0];
          end
        end
        S_RUN: begin
          if (bus.stop || (wrap && !loop_r)) begin
            state  <= S_IDLE;
            done_q <= !bus.stop;
            busy_q <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
          end else begin
            div_cnt    <= div_n;
            scroll_cnt <= scroll_n;
            offset     <= offset_n;
            dig        <= dig_n;
            sel_q      <= SEL0 << dig_n;
            data_q     <= mem[rd_idx];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with CLK_DIV=2, SCROLL_TICKS=3.
module tb_seg_scroll_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [7:0] p3 [3] = '{8'h6D, 8'h79, 8'h73};
  logic [7:0] p4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  seg_scroll_if #(.NUM_DIGITS(3), .MSG_DEPTH(16)) bus ();

  seg_scroll_ctrl #(
    .CLK_DIV(2), .SCROLL_TICKS(3), .NUM_DIGITS(3), .MSG_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [2:0] s, input logic [7:0] d,
                      input logic b, input logic dn);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".data"}, 32'(bus.data), 32'(d));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic lp);
    bus.msg_len = len;
    bus.loop = lp;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int off, dg;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.msg_len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;

    // reset and idle
    repeat (3) step();
    outs("rst", 3'b000, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) begin
      step();
      outs("idle", 3'b000, 8'h00, 1'b0, 1'b0);
    end

    // refresh sequencing, len 3
    for (int i = 0; i < 3; i++) wr(4'(i), p3[i]);
    do_start(5'd3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      outs("refresh", 3'(1 << (k / 2)), p3[k / 2], 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    outs("stop1", 3'b000, 8'h00, 1'b0, 1'b0);

    // scroll, len 4 looping; full cycle of offsets and back to 0
    for (int i = 0; i < 4; i++) wr(4'(i), p4[i]);
    do_start(5'd4, 1'b1);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) step();
      off = (k / 6) % 4;
      dg = (k / 2) % 3;
      outs("scroll", 3'(1 << dg), p4[(off + dg) % 4], 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    outs("stop2", 3'b000, 8'h00, 1'b0, 1'b0);

    // single pass: four scroll steps, wrap at the fourth ends the run
    do_start(5'd4, 1'b0);
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      off = (k / 6) % 4;
      dg = (k / 2) % 3;
      outs("pass", 3'(1 << dg), p4[(off + dg) % 4], 1'b1, 1'b0);
    end
    step();
    outs("pass_done", 3'b000, 8'h00, 1'b0, 1'b1);
    step();
    outs("pass_after", 3'b000, 8'h00, 1'b0, 1'b0);

    // restart at offset 0, live write to entry 1
    do_start(5'd4, 1'b1);
    outs("restart", 3'b001, 8'h11, 1'b1, 1'b0);
    wr(4'd1, 8'hFF);
    outs("live0", 3'b001, 8'h11, 1'b1, 1'b0);
    step();
    outs("live1", 3'b010, 8'hFF, 1'b1, 1'b0);

    // asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    outs("async_rst", 3'b000, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    outs("post_rst", 3'b000, 8'h00, 1'b0, 1'b0);

    // control edge cases
    do_start(5'd0, 1'b1);
    outs("len0", 3'b000, 8'h00, 1'b0, 1'b0);
    do_start(5'd17, 1'b1);
    outs("len17", 3'b000, 8'h00, 1'b0, 1'b0);
    bus.stop = 1'b1;
    do_start(5'd3, 1'b1);
    bus.stop = 1'b0;
    outs("start_stop", 3'b000, 8'h00, 1'b0, 1'b0);
    do_start(5'd16, 1'b1);
    chk("len16.busy", 32'(bus.busy), 32'd1);
    chk("len16.sel", 32'(bus.sel), 32'd1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    outs("len16_stop", 3'b000, 8'h00, 1'b0, 1'b0);

    // stop mid-run, no done pulse
    do_start(5'd4, 1'b1);
    step();
    step();
    outs("run_mid", 3'b010, 8'hFF, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    outs("stop_mid", 3'b000, 8'h00, 1'b0, 1'b0);
    step();
    outs("stop_mid2", 3'b000, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scroll_ctrl.md
Name: seg_scroll_ctrl

Overview:
Sequencer for the multiplexed 3-digit 7-segment display. Holds a loadable message buffer of segment patterns and time-multiplexes the digit selects at a refresh rate. It slides a NUM_DIGITS-wide window across the message at a programmable scroll rate, either once or looping. It replaces hard-coded per-digit patterns with a host-writable message and a start/stop control.

Parameters:
CLK_DIV, 100000, clk cycles per refresh tick (one digit slot); must be >= 1
SCROLL_TICKS, 300, refresh ticks per one-position scroll step; must be >= 1
NUM_DIGITS, 3, number of display digits (width of sel)
MSG_DEPTH, 16, message buffer entries; AW = $clog2(MSG_DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe for message buffer
wr_addr  in  AW  buffer entry to write
wr_data  in  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high
msg_len  in  AW+1  message length, sampled on accepted start
loop  in  1  1 = wrap continuously, 0 = single pass; sampled on accepted start
start  in  1  begin scrolling (level sampled each cycle)
stop  in  1  abort scrolling, blank display
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when a single pass completes
sel  out  NUM_DIGITS  one-hot digit enable; digit i -> bit i
data  out  8  segment pattern for the digit currently selected

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, sel=0, data=0; all counters, offset and digit index 0. Buffer contents are not reset; they are undefined until written.
- Buffer: on any cycle with wr_en=1, mem[wr_addr] <= wr_data. Writes are allowed in any state. A write during RUN becomes visible the next time that entry is displayed.
- FSM states: IDLE, RUN.
- IDLE -> RUN on start=1 and stop=0 when 1 <= msg_len <= MSG_DEPTH:
  - latch len and loop mode;
  - clear div_cnt, scroll_cnt, offset and dig to 0;
  - on the next cycle, busy=1, sel=1 (bit 0), data=mem[0].
  - start with an out-of-range msg_len is ignored and the block stays IDLE.
- In RUN, start is ignored.
- RUN -> IDLE on stop=1 (stop wins over simultaneous start). On the next cycle, sel=0, data=0 and busy=0. done is not pulsed.
- Refresh tick:
  - div_cnt counts 0..CLK_DIV-1; tick = (div_cnt == CLK_DIV-1), after which div_cnt returns to 0.
  - On tick, dig <= (dig == NUM_DIGITS-1) ? 0 : dig+1.
- Scroll:
  - scroll_cnt counts ticks 0..SCROLL_TICKS-1.
  - On a tick with scroll_cnt == SCROLL_TICKS-1: scroll_cnt <= 0 and offset <= offset+1, wrapping from len-1 to 0.
- Single pass (loop=0): when a scroll step would wrap offset from len-1 to 0, go to IDLE instead. That cycle's registered outputs are done=1, busy=0, sel=0, data=0. done is high for exactly one cycle.
- Output mapping:
  - sel and data are registered together and change on the same edge; they are never skewed by a cycle.
  - sel = one-hot(dig).
  - data = mem[(offset + dig) mod len]. The index uses AW+1-bit arithmetic with a conditional subtract of len; no divider is used.
  - When len < NUM_DIGITS the window wraps within the message, so characters repeat across digits.
- Scroll and digit-advance updates on the same tick both apply before the output register. The output always reflects the new offset and the new dig.
- rst_n asserted mid-RUN: outputs clear asynchronously and the state returns to IDLE.

Test Plan:
1. Reset/idle. Hold rst_n=0, then release with no start -> sel=0, data=0, busy=0 and done=0 indefinitely.
2. Refresh sequencing. CLK_DIV=2, SCROLL_TICKS=100, mem[0..2]=6D,79,73, msg_len=3, loop=1, start pulse ->
   - busy=1 next cycle;
   - sel cycles 001,010,100 with each value held 2 cycles;
   - data shows 6D, 79, 73 in matching slots.
3. Scroll step. CLK_DIV=2, SCROLL_TICKS=3, msg_len=4, mem=11,22,33,44, loop=1 ->
   - slots 0..2 show 11,22,33;
   - after 3 ticks they show 22,33,44, then 33,44,11, then 44,11,22, then back to 11,22,33.
4. Single pass. Same setup as scenario 3 with loop=0 -> after 4 scroll steps from start:
   - done=1 for exactly one cycle;
   - busy=0 and sel=0 on that same cycle;
   - a subsequent start restarts at offset 0.
5. Control edge cases:
   - start with msg_len=0 -> ignored;
   - start with msg_len=MSG_DEPTH+1 -> ignored;
   - start and stop together in IDLE -> stays IDLE;
   - stop mid-RUN -> sel=0, data=0 next cycle, no done pulse.
6. Live write and reset. During RUN, write mem[1]=FF -> the next display of entry 1 shows FF. Assert rst_n mid-RUN -> outputs go to 0 immediately, without waiting for a clock edge.
